// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: four-entry letter history scanned across the anodes.
// Optional newest-digit blinking is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_TICKS = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] letter_in,
   input  logic       letter_vld,
   input  logic       clr,
   output logic [3:0] an,
   output logic [4:0] digit_code,
   output logic [2:0] fill
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [PW-1:0] presc;
   logic          tick;
   logic [1:0]    idx;
   logic [4:0]    slot [4];
   logic [3:0]    valid;
   logic          cap;
   logic          blank;
   logic [3:0]    an_nxt;
   logic [4:0]    code_nxt;

   assign tick = (presc == PW'(REFRESH_DIV - 1));
   assign cap  = letter_vld & ~clr;

   // Scan timing never restarts on buffer activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= 2'd0;
      end else if (tick) begin
         presc <= '0;
         idx   <= idx + 2'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) slot[i] <= 5'd0;
         valid <= 4'b0000;
         fill  <= 3'd0;
      end else if (clr) begin
         valid <= 4'b0000;
         fill  <= 3'd0;
      end else if (cap) begin
         slot[3] <= slot[2];
         slot[2] <= slot[1];
         slot[1] <= slot[0];
         slot[0] <= letter_in;
         valid   <= {valid[2:0], 1'b1};
         if (fill != 3'd4) fill <= fill + 3'd1;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;

   logic [BW-1:0] bcnt;
   logic          phase;

   // A new letter always shows immediately, so the blink cycle restarts on it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (letter_vld) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (tick) begin
         if (bcnt == BW'(BLINK_TICKS - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end

   assign blank = ~phase & (idx == 2'd0);
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      an_nxt   = 4'b1111;
      code_nxt = 5'd0;
      if (valid[idx]) begin
         code_nxt = slot[idx];
         if (!blank) an_nxt = ~(4'b0001 << idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= 4'b1111;
         digit_code <= 5'd0;
      end else begin
         an         <= an_nxt;
         digit_code <= code_nxt;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (REFRESH_DIV=4; blink instance when SEG_SCAN_BLINK_EN).
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] letter_in = 5'd0;
   logic       letter_vld = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] an;
   logic [4:0] digit_code;
   logic [2:0] fill;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.REFRESH_DIV(4), .BLINK_TICKS(256)) u_dut (
      .clk(clk), .rst_n(rst_n), .letter_in(letter_in), .letter_vld(letter_vld),
      .clr(clr), .an(an), .digit_code(digit_code), .fill(fill)
   );

`ifdef SEG_SCAN_BLINK_EN
   logic [3:0] blk_an;
   logic [4:0] blk_code;
   logic [2:0] blk_fill;

   seg_scan_ctrl #(.REFRESH_DIV(2), .BLINK_TICKS(4)) u_blk (
      .clk(clk), .rst_n(rst_n), .letter_in(letter_in), .letter_vld(letter_vld),
      .clr(clr), .an(blk_an), .digit_code(blk_code), .fill(blk_fill)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves rst_n released mid-cycle; the next rising edge is edge 1.
   task automatic do_reset();
      letter_vld = 1'b0;
      clr        = 1'b0;
      rst_n      = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int bad, c_a, c_b, c_c, c_d, c_e;

      // idle after reset
      do_reset();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (an !== 4'b1111 || digit_code !== 5'd0 || fill !== 3'd0) bad++;
      end
      chk("idle_bad_cycles", bad, 0);
      chk("idle_an", an, 4'b1111);
      chk("idle_fill", fill, 0);

      // single letter: lit 4 of every 16 cycles
      do_reset();
      letter_in  = 5'd7;
      letter_vld = 1'b1;
      step();
      letter_vld = 1'b0;
      chk("one_fill", fill, 1);
      c_a = 0; c_b = 0; c_c = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (an === 4'b1110 && digit_code === 5'd7) c_a++;
         else if (an === 4'b1111) c_b++;
         else c_c++;
      end
      chk("one_lit", c_a, 8);
      chk("one_dark", c_b, 24);
      chk("one_other", c_c, 0);

      // five back-to-back letters, oldest discarded
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         letter_in  = 5'(k);
         letter_vld = 1'b1;
         step();
         chk($sformatf("fill_after_%0d", k), fill, (k > 4) ? 4 : k);
      end
      letter_vld = 1'b0;
      c_a = 0; c_b = 0; c_c = 0; c_d = 0; c_e = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (an === 4'b1110 && digit_code === 5'd5) c_a++;
         if (an === 4'b1101 && digit_code === 5'd4) c_b++;
         if (an === 4'b1011 && digit_code === 5'd3) c_c++;
         if (an === 4'b0111 && digit_code === 5'd2) c_d++;
         if (digit_code === 5'd1) c_e++;
      end
      chk("full_an0_5", c_a, 4);
      chk("full_an1_4", c_b, 4);
      chk("full_an2_3", c_c, 4);
      chk("full_an3_2", c_d, 4);
      chk("full_code1_gone", c_e, 0);

      // clr wins over simultaneous strobe
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         letter_in  = 5'(k);
         letter_vld = 1'b1;
         step();
      end
      letter_in = 5'd9;
      clr       = 1'b1;
      step();
      clr        = 1'b0;
      letter_vld = 1'b0;
      chk("clr_fill", fill, 0);
      c_a = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (an === 4'b1111 && digit_code === 5'd0) c_a++;
      end
      chk("clr_dark_cycles", c_a, 16);
      letter_vld = 1'b1;
      step();
      letter_vld = 1'b0;
      chk("clr_then_load_fill", fill, 1);

      // asynchronous reset mid-cycle, then scan timing from release
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         letter_in  = 5'(k + 10);
         letter_vld = 1'b1;
         step();
      end
      letter_vld = 1'b0;
      for (int i = 0; i < 5; i++) step();
      #3 rst_n = 1'b0;
      #1;
      chk("async_an", an, 4'b1111);
      chk("async_code", digit_code, 0);
      chk("async_fill", fill, 0);
      step();
      step();
      rst_n      = 1'b1;
      letter_in  = 5'd4;
      letter_vld = 1'b1;
      step();
      letter_vld = 1'b0;
      chk("rel_e1_an", an, 4'b1111);
      step();
      chk("rel_e2_an", an, 4'b1110);
      chk("rel_e2_code", digit_code, 4);
      step();
      step();
      chk("rel_e4_an", an, 4'b1110);
      step();
      chk("rel_e5_an", an, 4'b1111);
      for (int i = 0; i < 12; i++) step();
      chk("rel_e17_an", an, 4'b1110);

`ifdef SEG_SCAN_BLINK_EN
      // blink: REFRESH_DIV=2, BLINK_TICKS=4
      do_reset();
      letter_in  = 5'd3;
      letter_vld = 1'b1;
      step();
      letter_vld = 1'b0;
      step();
      chk("blk_on_an", blk_an, 4'b1110);
      chk("blk_on_code", blk_code, 3);
      for (int i = 0; i < 6; i++) step();
      letter_in  = 5'd6;
      letter_vld = 1'b1;
      step();
      letter_vld = 1'b0;
      chk("blk_off_an", blk_an, 4'b1111);
      step();
      chk("blk_retrig_an", blk_an, 4'b1110);
      chk("blk_retrig_code", blk_code, 6);
      c_a = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (blk_an === 4'b1110) c_a++;
      end
      chk("blk_lit_cycles", c_a, 8);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
